control_unit: RTL and testbench
===============================

# control_unit

Hardwired Moore control sequencer for the 32-bit bus-based datapath: it steps each instruction through fetch, decode and execute T-states and drives every bus-gate, register-load and ALU-select strobe the datapath consumes. It sits directly upstream of the `Datapath` block and replaces the per-state stimulus a bench would otherwise hand-drive. It reads only the instruction register contents and a memory-ready handshake from the datapath side.

## Interface
- No parameters; all encodings come from `cpu_ctrl_pkg`.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `ir`  in  32  IR contents; opcode `ir[31:27]`, Ra `ir[26:23]`, Rb `ir[22:19]`, Rc `ir[18:15]`.
- `mem_ready`  in  1  memory completed the current Read/Write this cycle.
- `PCout, Zlowout, Zhighout, MDRout, Cout, BAout`  out  1 each  bus drivers.
- `MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin`  out  1 each  register loads.
- `IncPC, Read, Write`  out  1 each.
- `Gra, Grb, Grc, Rin, Rout`  out  1 each  select-and-encode controls.
- `alu_op`  out  4  ALU function, `ALU_ADD` when idle.
- `run`  out  1  high unless halted.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- All outputs are a combinational decode of the registered state and `ir`. Each state is one clock unless it waits on `mem_ready`.
- States: `S_RESET, T0..T7, S_HALT`.
- Fetch path:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Hold T1 while `mem_ready`=0.
  - T2: MDRout, IRin.
  - T2 -> T3, except: nop/illegal go to T0; halt goes to `S_HALT`.
- Reg ALU ops (add, sub, and, or, ror, rol, shr, shra, shl):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, alu_op, Zin.
  - T5: Zlowout, Gra, Rin. Then T0.
- Immediate ops (addi, andi, ori): same as reg ALU ops, but T4 drives Cout instead of Grc/Rout.
- neg, not:
  - T3: Grb, Rout, alu_op, Zin.
  - T4: Zlowout, Gra, Rin. Then T0.
- mul, div (when compiled in):
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, alu_op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin. Then T0.
- ld, ldi, st address phase:
  - T3: Grb, BAout, Yin.
  - T4: Cout, alu_op=ADD, Zin.
- ldi finishes with T5: Zlowout, Gra, Rin.
- ld:
  - T5: Zlowout, MARin.
  - T6: Read, MDRin. Hold while `mem_ready`=0.
  - T7: MDRout, Gra, Rin.
- st:
  - T5: Zlowout, MARin.
  - T6: Gra, Rout, MDRin with Read=0.
  - T7: Write. Hold while `mem_ready`=0.
- `S_HALT`: all strobes 0, `run`=0. Exit only through `reset`.
- Illegal opcodes (and mul/div when compiled out) behave as nop and pulse `illegal` in T2.

## Timing
- Reset:
  - `reset` high at an edge puts the FSM in `S_RESET`, from any state including a wait state.
  - In `S_RESET` every output is 0 except `run`=1, and `alu_op`=ADD.
  - First edge with `reset` low moves to T0.
- Latency: reg ALU op 6 cycles; neg/not 5; mul/div 7; ldi 6; ld/st 8 plus memory wait cycles; nop 3.
- `mem_ready` is sampled only in T1, ld-T6 and st-T7. Elsewhere it is ignored.
- `mem_ready` high in the first cycle of a wait state gives zero wait states.
- Strobes assert for exactly the cycles their state is resident. Read and Write are never high in the same cycle.
- `ir` must be stable from T3 to the end of the instruction. It is reloaded only in T2.

## Configuration
- `CU_MULDIV_EN` defined: mul (10000) and div (01111) decode and use T3–T6 as above.
- Not defined: those opcodes are illegal (nop plus `illegal` pulse); `HIin`, `LOin` and `Zhighout` are tied to 0.

## Structure
- `cpu_ctrl_pkg` holds:
  - 5-bit opcode constants: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, ror=00111, rol=01000, shr=01001, shra=01010, shl=01011, addi=01100, andi=01101, ori=01110, div=01111, mul=10000, neg=10001, not=10010, nop=11010, halt=11011.
  - the 4-bit `alu_op` enum and the state enum.
- One sub-module, `instr_class_decode` (combinational): maps the opcode to the instruction class plus `alu_op`.

## Test plan
- and R1,R2,R3: reset, then `ir`=0x28918000, `mem_ready`=1 -> T3 Grb+Rout+Yin; T4 Grc+Rout+alu_op=AND+Zin; T5 Zlowout+Gra+Rin; back to T0 on cycle 7.
- Fetch wait: `mem_ready` low for 3 cycles in T1 -> Read and MDRin held 4 cycles, PCin high throughout, IRin exactly 1 cycle.
- ld R2,0x45(R1) (`ir`=0x01080045): T5 MARin, T6 Read for 2 cycles (`mem_ready` late), T7 MDRout+Gra+Rin; total 9 cycles.
- st: T6 MDRin with Read=0, T7 Write until `mem_ready`; Read never coincides with Write.
- `reset` pulsed during ld T6 -> next state `S_RESET`, all strobes 0, then T0.
- halt (0xD8000000) -> `S_HALT`, `run`=0, held until reset. Opcode 11111 -> `illegal` pulses 1 cycle, returns to T0. With `CU_MULDIV_EN` undefined, mul behaves the same way.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, ALU functions,
// T-state and instruction-class enums.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_ROR, ALU_ROL, ALU_SHR,
        ALU_SHRA, ALU_SHL, ALU_MUL, ALU_DIV, ALU_NEG, ALU_NOT
    } alu_op_e;

    typedef enum logic [3:0] {
        S_RESET, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_NOP, C_ILL, C_HALT, C_ALU, C_IMM, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST
    } iclass_e;

endpackage

// File: rtl/control_unit_if.sv
// Strobe bundle between the control sequencer (master) and the datapath (slave).
interface control_unit_if;
    import cpu_ctrl_pkg::*;

    logic [31:0] ir;
    logic        mem_ready;
    logic        PCout, Zlowout, Zhighout, MDRout, Cout, BAout;
    logic        MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin;
    logic        IncPC, Read, Write;
    logic        Gra, Grb, Grc, Rin, Rout;
    alu_op_e     alu_op;
    logic        run, illegal;

    modport master (
        input  ir, mem_ready,
        output PCout, Zlowout, Zhighout, MDRout, Cout, BAout,
        output MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin,
        output IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout,
        output alu_op, run, illegal
    );

    modport slave (
        output ir, mem_ready,
        input  PCout, Zlowout, Zhighout, MDRout, Cout, BAout,
        input  MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin,
        input  IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout,
        input  alu_op, run, illegal
    );

endinterface

// File: rtl/instr_class_decode.sv
// Opcode -> instruction class and ALU function. mul/div decode only when
// CU_MULDIV_EN is defined; otherwise they fall out as illegal.
module instr_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode_i,
    output iclass_e    iclass_o,
    output alu_op_e    alu_op_o
);

    always_comb begin
        iclass_o = C_ILL;
        alu_op_o = ALU_ADD;
        case (opcode_i)
            OP_LD:   iclass_o = C_LD;
            OP_LDI:  iclass_o = C_LDI;
            OP_ST:   iclass_o = C_ST;
            OP_ADD:  iclass_o = C_ALU;
            OP_SUB:  begin iclass_o = C_ALU; alu_op_o = ALU_SUB;  end
            OP_AND:  begin iclass_o = C_ALU; alu_op_o = ALU_AND;  end
            OP_OR:   begin iclass_o = C_ALU; alu_op_o = ALU_OR;   end
            OP_ROR:  begin iclass_o = C_ALU; alu_op_o = ALU_ROR;  end
            OP_ROL:  begin iclass_o = C_ALU; alu_op_o = ALU_ROL;  end
            OP_SHR:  begin iclass_o = C_ALU; alu_op_o = ALU_SHR;  end
            OP_SHRA: begin iclass_o = C_ALU; alu_op_o = ALU_SHRA; end
            OP_SHL:  begin iclass_o = C_ALU; alu_op_o = ALU_SHL;  end
            OP_ADDI: iclass_o = C_IMM;
            OP_ANDI: begin iclass_o = C_IMM; alu_op_o = ALU_AND;  end
            OP_ORI:  begin iclass_o = C_IMM; alu_op_o = ALU_OR;   end
            OP_MUL:  begin
`ifdef CU_MULDIV_EN
                iclass_o = C_MULDIV; alu_op_o = ALU_MUL;
`endif
            end
            OP_DIV:  begin
`ifdef CU_MULDIV_EN
                iclass_o = C_MULDIV; alu_op_o = ALU_DIV;
`endif
            end
            OP_NEG:  begin iclass_o = C_UNARY; alu_op_o = ALU_NEG; end
            OP_NOT:  begin iclass_o = C_UNARY; alu_op_o = ALU_NOT; end
            OP_NOP:  iclass_o = C_NOP;
            OP_HALT: iclass_o = C_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch/decode/execute T-states driving datapath strobes.
// CU_MULDIV_EN adds the mul/div T3-T6 sequence and the HI/LO/Zhigh strobes.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input logic            clock,
    input logic            reset,
    control_unit_if.master bus
);

    state_e  state_q, state_d;
    iclass_e iclass;
    alu_op_e dec_alu;

    instr_class_decode u_dec (
        .opcode_i (bus.ir[31:27]),
        .iclass_o (iclass),
        .alu_op_o (dec_alu)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.PCout    = 1'b0; bus.Zlowout = 1'b0; bus.Zhighout = 1'b0;
        bus.MDRout   = 1'b0; bus.Cout    = 1'b0; bus.BAout    = 1'b0;
        bus.MARin    = 1'b0; bus.MDRin   = 1'b0; bus.PCin     = 1'b0;
        bus.IRin     = 1'b0; bus.Yin     = 1'b0; bus.Zin      = 1'b0;
        bus.HIin     = 1'b0; bus.LOin    = 1'b0; bus.IncPC    = 1'b0;
        bus.Read     = 1'b0; bus.Write   = 1'b0;
        bus.Gra      = 1'b0; bus.Grb     = 1'b0; bus.Grc      = 1'b0;
        bus.Rin      = 1'b0; bus.Rout    = 1'b0;
        bus.alu_op   = ALU_ADD;
        bus.run      = 1'b1;
        bus.illegal  = 1'b0;
        case (state_q)
            T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                state_d = T1;
            end
            T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
                if (bus.mem_ready) state_d = T2;
            end
            T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                case (iclass)
                    C_NOP:   state_d = T0;
                    C_ILL:   begin bus.illegal = 1'b1; state_d = T0; end
                    C_HALT:  state_d = S_HALT;
                    default: state_d = T3;
                endcase
            end
            T3: begin
                state_d = T4;
                case (iclass)
                    C_UNARY: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.alu_op = dec_alu; bus.Zin = 1'b1;
                    end
                    C_MULDIV:         begin bus.Gra = 1'b1; bus.Rout  = 1'b1; bus.Yin = 1'b1; end
                    C_LD, C_LDI, C_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
                    default:          begin bus.Grb = 1'b1; bus.Rout  = 1'b1; bus.Yin = 1'b1; end
                endcase
            end
            T4: begin
                state_d = T5;
                case (iclass)
                    C_UNARY: begin
                        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                        state_d = T0;
                    end
                    C_MULDIV: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.alu_op = dec_alu; bus.Zin = 1'b1;
                    end
                    // Immediate and address arithmetic both take the offset from C
                    C_IMM, C_LD, C_LDI, C_ST: begin
                        bus.Cout = 1'b1; bus.alu_op = dec_alu; bus.Zin = 1'b1;
                    end
                    default: begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.alu_op = dec_alu; bus.Zin = 1'b1;
                    end
                endcase
            end
            T5: begin
                case (iclass)
                    C_MULDIV: begin
`ifdef CU_MULDIV_EN
                        bus.Zlowout = 1'b1; bus.LOin = 1'b1;
`endif
                        state_d = T6;
                    end
                    C_LD, C_ST: begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; state_d = T6; end
                    default:    begin
                        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T6: begin
                case (iclass)
                    C_MULDIV: begin
`ifdef CU_MULDIV_EN
                        bus.Zhighout = 1'b1; bus.HIin = 1'b1;
`endif
                        state_d = T0;
                    end
                    C_LD: begin
                        bus.Read = 1'b1; bus.MDRin = 1'b1;
                        if (bus.mem_ready) state_d = T7;
                    end
                    // st: store data goes to MDR from the register file, not memory
                    default: begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
                        state_d = T7;
                    end
                endcase
            end
            T7: begin
                if (iclass == C_ST) begin
                    bus.Write = 1'b1;
                    if (bus.mem_ready) state_d = T0;
                end else begin
                    bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    state_d = T0;
                end
            end
            S_HALT: bus.run = 1'b0;
            default: state_d = T0;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected strobe words are queued by
// the stimulus and checked by an independent monitor on the falling edge.
module tb_control_unit;
    import cpu_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    control_unit_if bus();

    control_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] M_PCOUT  = 32'd1 << 0;
    localparam logic [31:0] M_ZLOW   = 32'd1 << 1;
    localparam logic [31:0] M_ZHIGH  = 32'd1 << 2;
    localparam logic [31:0] M_MDROUT = 32'd1 << 3;
    localparam logic [31:0] M_COUT   = 32'd1 << 4;
    localparam logic [31:0] M_BAOUT  = 32'd1 << 5;
    localparam logic [31:0] M_MARIN  = 32'd1 << 6;
    localparam logic [31:0] M_MDRIN  = 32'd1 << 7;
    localparam logic [31:0] M_PCIN   = 32'd1 << 8;
    localparam logic [31:0] M_IRIN   = 32'd1 << 9;
    localparam logic [31:0] M_YIN    = 32'd1 << 10;
    localparam logic [31:0] M_ZIN    = 32'd1 << 11;
    localparam logic [31:0] M_HIIN   = 32'd1 << 12;
    localparam logic [31:0] M_LOIN   = 32'd1 << 13;
    localparam logic [31:0] M_INCPC  = 32'd1 << 14;
    localparam logic [31:0] M_READ   = 32'd1 << 15;
    localparam logic [31:0] M_WRITE  = 32'd1 << 16;
    localparam logic [31:0] M_GRA    = 32'd1 << 17;
    localparam logic [31:0] M_GRB    = 32'd1 << 18;
    localparam logic [31:0] M_GRC    = 32'd1 << 19;
    localparam logic [31:0] M_RIN    = 32'd1 << 20;
    localparam logic [31:0] M_ROUT   = 32'd1 << 21;
    localparam logic [31:0] RUN      = 32'd1 << 28;
    localparam logic [31:0] ILL      = 32'd1 << 29;

    localparam logic [31:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | RUN;
    localparam logic [31:0] F1 = M_ZLOW | M_PCIN | M_READ | M_MDRIN | RUN;
    localparam logic [31:0] F2 = M_MDROUT | M_IRIN | RUN;

    typedef struct {
        logic [31:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] al(alu_op_e a);
        return {4'b0, a, 24'b0};
    endfunction

    function automatic logic [31:0] snap();
        return {2'b0, bus.illegal, bus.run, bus.alu_op, 2'b0,
                bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.Write, bus.Read,
                bus.IncPC, bus.LOin, bus.HIin, bus.Zin, bus.Yin, bus.IRin, bus.PCin,
                bus.MDRin, bus.MARin, bus.BAout, bus.Cout, bus.MDRout, bus.Zhighout,
                bus.Zlowout, bus.PCout};
    endfunction

    always @(negedge clock) begin
        logic [31:0] got;
        exp_t        e;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = snap();
            n_cmp++;
            if (got !== e.v) begin
                n_bad++;
                $display("FAIL %s: strobes got %h expected %h (ir=%h)", e.tag, got, e.v, bus.ir);
            end
            n_cmp++;
            if (bus.Read && bus.Write) begin
                n_bad++;
                $display("FAIL %s.rw_excl: Read=%b Write=%b required not both 1",
                         e.tag, bus.Read, bus.Write);
            end
        end
    end

    task automatic cyc(input logic rst, input logic mr, input logic [31:0] v, input string tag);
        exp_t e;
        reset         = rst;
        bus.mem_ready = mr;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // T0 with mem_ready low (ignored there), T1 completes at once, then T2.
    task automatic fetch(input string t, input logic [31:0] t2_extra);
        cyc(0, 0, F0, {t, ".T0"});
        cyc(0, 1, F1, {t, ".T1"});
        cyc(0, 1, F2 | t2_extra, {t, ".T2"});
    endtask

    initial begin
        bus.ir        = '0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        cyc(0, 0, RUN, "reset");

        // and R1,R2,R3
        bus.ir = 32'h2891_8000;
        fetch("and", 32'd0);
        cyc(0, 1, M_GRB | M_ROUT | M_YIN | RUN, "and.T3");
        cyc(0, 1, M_GRC | M_ROUT | M_ZIN | al(ALU_AND) | RUN, "and.T4");
        cyc(0, 1, M_ZLOW | M_GRA | M_RIN | RUN, "and.T5");

        // nop with three fetch wait states
        bus.ir = 32'hD000_0000;
        cyc(0, 1, F0, "wait.T0");
        cyc(0, 0, F1, "wait.T1a");
        cyc(0, 0, F1, "wait.T1b");
        cyc(0, 0, F1, "wait.T1c");
        cyc(0, 1, F1, "wait.T1d");
        cyc(0, 0, F2, "wait.T2");

        // ld R2,0x45(R1), one memory wait
        bus.ir = 32'h0108_0045;
        fetch("ld", 32'd0);
        cyc(0, 0, M_GRB | M_BAOUT | M_YIN | RUN, "ld.T3");
        cyc(0, 0, M_COUT | M_ZIN | al(ALU_ADD) | RUN, "ld.T4");
        cyc(0, 0, M_ZLOW | M_MARIN | RUN, "ld.T5");
        cyc(0, 0, M_READ | M_MDRIN | RUN, "ld.T6a");
        cyc(0, 1, M_READ | M_MDRIN | RUN, "ld.T6b");
        cyc(0, 0, M_MDROUT | M_GRA | M_RIN | RUN, "ld.T7");

        // st, mem_ready low in T6 must not stall
        bus.ir = 32'h1108_0010;
        fetch("st", 32'd0);
        cyc(0, 0, M_GRB | M_BAOUT | M_YIN | RUN, "st.T3");
        cyc(0, 0, M_COUT | M_ZIN | RUN, "st.T4");
        cyc(0, 0, M_ZLOW | M_MARIN | RUN, "st.T5");
        cyc(0, 0, M_GRA | M_ROUT | M_MDRIN | RUN, "st.T6");
        cyc(0, 0, M_WRITE | RUN, "st.T7a");
        cyc(0, 1, M_WRITE | RUN, "st.T7b");

        // reset while ld waits in T6
        bus.ir = 32'h0108_0045;
        fetch("ldrst", 32'd0);
        cyc(0, 0, M_GRB | M_BAOUT | M_YIN | RUN, "ldrst.T3");
        cyc(0, 0, M_COUT | M_ZIN | RUN, "ldrst.T4");
        cyc(0, 0, M_ZLOW | M_MARIN | RUN, "ldrst.T5");
        cyc(1, 0, M_READ | M_MDRIN | RUN, "ldrst.T6");
        cyc(0, 0, RUN, "ldrst.S_RESET");

        // addi
        bus.ir = 32'h6000_0000;
        fetch("addi", 32'd0);
        cyc(0, 1, M_GRB | M_ROUT | M_YIN | RUN, "addi.T3");
        cyc(0, 1, M_COUT | M_ZIN | al(ALU_ADD) | RUN, "addi.T4");
        cyc(0, 1, M_ZLOW | M_GRA | M_RIN | RUN, "addi.T5");

        // neg
        bus.ir = 32'h8800_0000;
        fetch("neg", 32'd0);
        cyc(0, 1, M_GRB | M_ROUT | M_ZIN | al(ALU_NEG) | RUN, "neg.T3");
        cyc(0, 1, M_ZLOW | M_GRA | M_RIN | RUN, "neg.T4");

        // ldi
        bus.ir = 32'h0800_0000;
        fetch("ldi", 32'd0);
        cyc(0, 1, M_GRB | M_BAOUT | M_YIN | RUN, "ldi.T3");
        cyc(0, 1, M_COUT | M_ZIN | RUN, "ldi.T4");
        cyc(0, 1, M_ZLOW | M_GRA | M_RIN | RUN, "ldi.T5");

        // opcode 11111
        bus.ir = 32'hF800_0000;
        fetch("ill", ILL);

        // mul
        bus.ir = 32'h8000_0000;
`ifdef CU_MULDIV_EN
        fetch("mul", 32'd0);
        cyc(0, 1, M_GRA | M_ROUT | M_YIN | RUN, "mul.T3");
        cyc(0, 1, M_GRB | M_ROUT | M_ZIN | al(ALU_MUL) | RUN, "mul.T4");
        cyc(0, 1, M_ZLOW | M_LOIN | RUN, "mul.T5");
        cyc(0, 1, M_ZHIGH | M_HIIN | RUN, "mul.T6");
`else
        fetch("mul", ILL);
`endif

        // halt, held until reset
        bus.ir = 32'hD800_0000;
        fetch("halt", 32'd0);
        cyc(0, 1, 32'd0, "halt.h0");
        cyc(0, 1, 32'd0, "halt.h1");
        cyc(0, 0, 32'd0, "halt.h2");
        cyc(1, 0, 32'd0, "halt.h3");
        cyc(0, 0, RUN, "halt.S_RESET");
        cyc(0, 0, F0, "final.T0");

        repeat (3) @(negedge clock);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
